// File: rtl/usr_param.sv
// rtl/usr_param.sv - Multi-mode shift register with counted burst-shift FSM
//
// Purpose:
//   WIDTH-bit register with these per-cycle modes:
//     hold, shift left, shift right, load, rotate left, rotate right,
//     arithmetic shift right and clear.
//   A burst engine (IDLE -> RUN -> DONE) repeats one latched shift-class mode
//   'count' times, then emits a one-cycle done pulse.
//
// Configuration macro:
//   USR_ROTATE_EN - when defined, modes 100/101 rotate and can start a burst.
//                   When undefined, modes 100/101 act as hold and a start with
//                   them is ignored.
//
// Ports:
//   clk         in   single clock, rising edge
//   reset       in   asynchronous, active-low
//   en          in   operation enable; low holds q in IDLE and stalls a burst
//   mode[2:0]   in   000 hold, 001 shl, 010 shr, 011 load,
//                    100 rotl, 101 rotr, 110 asr, 111 clear
//   inp         in   parallel load data (WIDTH bits)
//   serialin_l  in   fill bit entering the LSB on shl
//   serialin_r  in   fill bit entering the MSB on shr
//   start       in   burst request
//   count       in   burst shift count (CNT_W bits)
//   q           out  register contents
//   sout_l      out  q[WIDTH-1]
//   sout_r      out  q[0]
//   busy        out  high while the burst FSM is in RUN
//   done        out  one-cycle burst completion pulse
module usr_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] inp,
  input  logic             serialin_l,
  input  logic             serialin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHL   = 3'b001;
  localparam logic [2:0] M_SHR   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ROTL  = 3'b100;
  localparam logic [2:0] M_ROTR  = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] remaining;
  logic [2:0]       mode_l;

  // Modes that may be repeated by a burst.
  function automatic logic is_shift(input logic [2:0] m);
    logic r;
    r = 1'b0;
    case (m)
      M_SHL, M_SHR, M_ASR: r = 1'b1;
`ifdef USR_ROTATE_EN
      M_ROTL, M_ROTR:      r = 1'b1;
`endif
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

  // Next register value for one application of mode m.
  function automatic logic [WIDTH-1:0] apply_mode(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] d,
    input logic             fill_l,
    input logic             fill_r
  );
    logic [WIDTH-1:0] r;
    r = cur;
    case (m)
      M_HOLD:  r = cur;
      M_SHL:   r = {cur[WIDTH-2:0], fill_l};
      M_SHR:   r = {fill_r, cur[WIDTH-1:1]};
      M_LOAD:  r = d;
`ifdef USR_ROTATE_EN
      M_ROTL:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ROTR:  r = {cur[0], cur[WIDTH-1:1]};
`endif
      M_ASR:   r = {cur[WIDTH-1], cur[WIDTH-1:1]};
      M_CLEAR: r = '0;
      default: r = cur;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q         <= '0;
      state     <= S_IDLE;
      remaining <= '0;
      mode_l    <= M_HOLD;
    end else begin
      case (state)
        S_IDLE: begin
          // A burst accept ignores en and leaves q untouched on this edge.
          if (start && is_shift(mode)) begin
            mode_l    <= mode;
            remaining <= count;
            state     <= (count != '0) ? S_RUN : S_DONE;
          end else if (en) begin
            q <= apply_mode(mode, q, inp, serialin_l, serialin_r);
          end
        end
        S_RUN: begin
          if (en) begin
            q         <= apply_mode(mode_l, q, inp, serialin_l, serialin_r);
            remaining <= remaining - CNT_W'(1);
            // Leaving at 1 means remaining never wraps below zero.
            if (remaining == CNT_W'(1)) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Status decodes straight from state so reset clears them without an edge.
  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_usr_param.sv
// tb/tb_usr_param.sv - Scoreboard testbench for usr_param (WIDTH=8, CNT_W=4)
module tb_usr_param;

  logic       clk;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic [7:0] inp;
  logic       serialin_l;
  logic       serialin_r;
  logic       start;
  logic [3:0] count;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] q;
    logic       busy;
    logic       done;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  usr_param #(.WIDTH(8), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mode       (mode),
    .inp        (inp),
    .serialin_l (serialin_l),
    .serialin_r (serialin_r),
    .start      (start),
    .count      (count),
    .q          (q),
    .sout_l     (sout_l),
    .sout_r     (sout_r),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] eq, input logic eb, input logic ed);
    logic [11:0] act;
    logic [11:0] req;
    act = {q, sout_l, sout_r, busy, done};
    req = {eq, eq[7], eq[0], eb, ed};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got q=%b sout_l=%b sout_r=%b busy=%b done=%b, expected q=%b sout_l=%b sout_r=%b busy=%b done=%b",
               name, q, sout_l, sout_r, busy, done, eq, eq[7], eq[0], eb, ed);
    end
  endtask

  // Clock one edge with the currently driven inputs and queue the state
  // expected after that edge; the monitor checks it at the next falling edge.
  task automatic step(input string name, input logic [7:0] eq, input logic eb, input logic ed);
    exp_t e;
    @(posedge clk);
    e.q = eq;
    e.busy = eb;
    e.done = ed;
    e.name = name;
    exp_q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk(mon_e.name, mon_e.q, mon_e.busy, mon_e.done);
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    reset = 1'b0;
    en = 1'b0;
    mode = 3'b000;
    inp = 8'h00;
    serialin_l = 1'b0;
    serialin_r = 1'b0;
    start = 1'b0;
    count = 4'd0;
    #2;
    chk("reset_state", 8'b00000000, 1'b0, 1'b0);
    #10;
    reset = 1'b1;

    // Scenario 1: load then hold; en low holds even with clear selected.
    en = 1'b1; mode = 3'b011; inp = 8'b10111001;
    step("s1_load", 8'b10111001, 1'b0, 1'b0);
    mode = 3'b000;
    step("s1_hold1", 8'b10111001, 1'b0, 1'b0);
    step("s1_hold2", 8'b10111001, 1'b0, 1'b0);
    en = 1'b0; mode = 3'b111;
    step("en_low_hold", 8'b10111001, 1'b0, 1'b0);

    // Scenario 2: shl twice with fill 0, shr once with fill 1.
    en = 1'b1; mode = 3'b011; inp = 8'b11110000;
    step("s2_load", 8'b11110000, 1'b0, 1'b0);
    mode = 3'b001; serialin_l = 1'b0;
    step("s2_shl1", 8'b11100000, 1'b0, 1'b0);
    step("s2_shl2", 8'b11000000, 1'b0, 1'b0);
    mode = 3'b010; serialin_r = 1'b1;
    step("s2_shr", 8'b11100000, 1'b0, 1'b0);

    // Scenario 3: asr then rotr.
    mode = 3'b011; inp = 8'b10000001;
    step("s3_load", 8'b10000001, 1'b0, 1'b0);
    mode = 3'b110;
    step("s3_asr", 8'b11000000, 1'b0, 1'b0);
    mode = 3'b101;
`ifdef USR_ROTATE_EN
    step("s3_rotr", 8'b01100000, 1'b0, 1'b0);
`else
    step("s3_rotr_as_hold", 8'b11000000, 1'b0, 1'b0);
`endif

    // Scenario 4: rotl burst of 3; a start during DONE is ignored.
    mode = 3'b011; inp = 8'b10110000;
    step("s4_load", 8'b10110000, 1'b0, 1'b0);
    start = 1'b1; mode = 3'b100; count = 4'd3;
`ifdef USR_ROTATE_EN
    step("s4_accept", 8'b10110000, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b000;
    step("s4_run1", 8'b01100001, 1'b1, 1'b0);
    step("s4_run2", 8'b11000010, 1'b1, 1'b0);
    step("s4_done", 8'b10000101, 1'b0, 1'b1);
    start = 1'b1; mode = 3'b001; count = 4'd2;
    step("s4_idle_after_done", 8'b10000101, 1'b0, 1'b0);
    start = 1'b0; mode = 3'b000;
    step("s4_start_in_done_ignored", 8'b10000101, 1'b0, 1'b0);
`else
    step("s4_rotl_start_ignored", 8'b10110000, 1'b0, 1'b0);
    start = 1'b0; mode = 3'b000;
    step("s4_still_idle", 8'b10110000, 1'b0, 1'b0);
`endif

    // Scenario 5a: count=0 burst accepted with en low goes straight to DONE.
    en = 1'b1; mode = 3'b011; inp = 8'b10101010;
    step("s5_load", 8'b10101010, 1'b0, 1'b0);
    en = 1'b0; start = 1'b1; mode = 3'b001; count = 4'd0;
    step("s5_cnt0_done", 8'b10101010, 1'b0, 1'b1);
    start = 1'b0; mode = 3'b000;
    step("s5_cnt0_idle", 8'b10101010, 1'b0, 1'b0);

    // Scenario 5b: shr burst of 2 with a two-cycle stall; mode/inp ignored in RUN.
    en = 1'b1; start = 1'b1; mode = 3'b010; count = 4'd2;
    step("s5_shr_accept", 8'b10101010, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b011; inp = 8'hff; serialin_r = 1'b1;
    step("s5_shr_run1", 8'b11010101, 1'b1, 1'b0);
    en = 1'b0;
    step("s5_stall1", 8'b11010101, 1'b1, 1'b0);
    step("s5_stall2", 8'b11010101, 1'b1, 1'b0);
    en = 1'b1; serialin_r = 1'b0;
    step("s5_shr_done", 8'b01101010, 1'b0, 1'b1);
    mode = 3'b000;
    step("s5_shr_idle", 8'b01101010, 1'b0, 1'b0);

    // Scenario 6: asynchronous reset in the middle of a count=5 burst.
    mode = 3'b011; inp = 8'b00001111;
    step("s6_load", 8'b00001111, 1'b0, 1'b0);
    start = 1'b1; mode = 3'b001; count = 4'd5; serialin_l = 1'b1;
    step("s6_accept", 8'b00001111, 1'b1, 1'b0);
    start = 1'b0;
    step("s6_run1", 8'b00011111, 1'b1, 1'b0);
    step("s6_run2", 8'b00111111, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("s6_async_reset", 8'b00000000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("s6_reset_held", 8'b00000000, 1'b0, 1'b0);
    reset = 1'b1;
    mode = 3'b001; serialin_l = 1'b1;
    step("s6_first_edge_idle", 8'b00000001, 1'b0, 1'b0);
    mode = 3'b000;
    step("s6_no_done1", 8'b00000001, 1'b0, 1'b0);
    step("s6_no_done2", 8'b00000001, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
